// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and address-field constants for the instruction cache
package icache_pkg;

  localparam int ICACHE_NSETS = 16;
  localparam int IIDX_W       = $clog2(ICACHE_NSETS);
  localparam int IBYT_W       = 2;
  localparam int ITAG_W       = 32 - IIDX_W - IBYT_W;

  // Field view of a fetch address for the default geometry.
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-controller-side signals of the instruction cache
interface icache_if;

  // datapath fetch side
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;

  // memory controller side
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with one-word miss fill
module icache
  import icache_pkg::*;
#(
  parameter int NSETS = ICACHE_NSETS,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  icache_if.slave          bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state, next_state;

  logic [NSETS-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [NSETS];
  logic [31:0]      data_arr [NSETS];
  logic [31:0]      miss_addr;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             lookup_hit, hit, miss, fill;
  logic             unused_bits;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:IDX_W+2];

  // Byte offsets carry no information for word fetches.
  assign unused_bits = ^{bus.imemaddr[1:0], miss_addr[1:0]};

  assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign hit        = (state == IDLE) && bus.imemREN && lookup_hit;
  assign miss       = (state == IDLE) && bus.imemREN && !lookup_hit;
  // A fill completes whenever the controller answers, even if the fetch was redirected.
  assign fill       = (state == FETCH) && !bus.iwait;

  // State register: reset drops any outstanding fill immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state: leave IDLE on a miss, return once the controller delivers the word.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss) next_state = FETCH;
      FETCH:   if (fill) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: hits answer combinationally in IDLE, FETCH only drives the memory request.
  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    case (state)
      IDLE: begin
        bus.ihit     = hit;
        bus.imemload = hit ? data_arr[req_idx] : '0;
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr;
      end
      default: ;
    endcase
  end

  // Valid bits: cleared by reset, set by each completed fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     valid           <= '0;
    else if (fill) valid[fill_idx] <= 1'b1;
  end

  // Tag and data frames are don't-care until their valid bit is set, so no reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= bus.iload;
    end
  end

  // Miss address is captured in IDLE and held for the whole fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     miss_addr <= '0;
    else if (miss) miss_addr <= {bus.imemaddr[31:2], 2'b00};
  end

  // Hit counter: one count per cycle ihit is high, saturating.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                     hit_cnt <= '0;
    else if (hit && (~&hit_cnt))   hit_cnt <= hit_cnt + 1'b1;
  end

  // Miss counter: one count per fill started, saturating.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                     miss_cnt <= '0;
    else if (miss && (~&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
  end

endmodule
